uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  UART receiver: the receive end of the serial link whose transmit end is riscv_top's Tx pin.
//  Decodes 8N1 (or parity) frames with 16x oversampling, mid-bit sampling and start-bit glitch rejection.
//  Buffers bytes in a first-word-fall-through FIFO for the host-side interface.
//  Used in simulation (wired to top.Tx) to capture CPU output and in the hci path for Rx.
// PARAMETERS
//  SYS_CLK_FREQ     100_000_000  clk frequency in Hz
//  BAUD_RATE        115200       line rate in bit/s
//  DATA_BITS        8            data bits per frame, LSB first (5..8)
//  PARITY_MODE      0            0 = none, 1 = odd, 2 = even
//  FIFO_DEPTH_LOG2  3            FIFO holds 2**FIFO_DEPTH_LOG2 entries
// PORTS
//  clk         in   1                  system clock, rising edge
//  rst         in   1                  asynchronous, active-low reset (0 = reset)
//  rx          in   1                  serial line, idle high, asynchronous to clk
//  rd_en       in   1                  pop head entry when rd_valid=1
//  rd_data     out  DATA_BITS          FIFO head byte (valid while rd_valid=1)
//  rd_valid    out  1                  FIFO not empty
//  fifo_count  out  FIFO_DEPTH_LOG2+1  entries currently stored
//  busy        out  1                  FSM not in IDLE
//  frame_err   out  1                  1-cycle pulse: stop bit sampled 0
//  parity_err  out  1                  1-cycle pulse: parity mismatch
//  overrun     out  1                  1-cycle pulse: good byte dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE; rd_valid=0, fifo_count=0, busy=0; all pulses 0; rd_data=0;
//   FIFO pointers=0; synchroniser and edge register preset to 1.
//  rx passes a 2-FF synchroniser, giving 2 cycles of input latency.
//  Tick generator: DIV = SYS_CLK_FREQ/(BAUD_RATE*16), integer-truncated.
//   One-cycle tick every DIV clks; counter free-runs, cleared on IDLE->START.
//  FSM states: IDLE, START, DATA, PARITY, STOP. Sample counter is 4 bits and counts ticks.
//   IDLE:   on synchronised falling edge (prev=1, cur=0) -> START, clear sample ctr.
//   START:  on 8th tick, rx=0 -> DATA (ctr cleared); rx=1 -> IDLE (glitch, no error).
//   DATA:   every 16th tick, shift rx into bit DATA_BITS-1, shifting right.
//           After DATA_BITS samples -> PARITY if PARITY_MODE!=0, else STOP.
//   PARITY: on 16th tick, compare rx with computed parity and latch a mismatch flag -> STOP.
//   STOP:   on 16th tick, resolve the frame and -> IDLE in the same cycle:
//           rx=0          -> frame_err pulse, byte discarded (framing takes precedence over parity);
//           parity flag   -> parity_err pulse, byte discarded;
//           otherwise     -> push byte.
//  Line held low after a framing error does not retrigger: a new start needs a fresh 1->0 edge.
//  FIFO is first-word-fall-through:
//   Push occurs in the STOP resolve cycle.
//   rd_valid/rd_data update 1 cycle later; end-to-end ~9.5 bit times after start edge + 2 sync cycles.
//   rd_en with rd_valid=0 is ignored.
//   Push and pop in the same cycle: count unchanged; allowed when full (pop frees the slot, no overrun).
//   Push when full with no pop: byte dropped, overrun pulses, FIFO contents untouched.
//  Pointers wrap modulo 2**FIFO_DEPTH_LOG2; fifo_count ranges 0..2**FIFO_DEPTH_LOG2.
//  Reset asserted mid-frame: frame abandoned, FIFO emptied, no error pulse.
// TESTING  (bench override: SYS_CLK_FREQ=1_600_000, BAUD_RATE=10_000 -> DIV=10, 160 clk/bit)
//  1. Send 0x55, 8N1 -> rd_valid=1, rd_data=0x55, fifo_count=1, no error pulses; rd_en -> rd_valid=0.
//  2. rx low for 40 clk (< half bit), then high -> FSM returns to IDLE, no push, no error.
//  3. Send 0xA3 with stop bit forced 0 -> frame_err pulses once, fifo_count stays 0;
//     hold rx low 2 bits, then send 0x11 -> 0x11 received.
//  4. PARITY_MODE=2: send 0x07 with parity 1 (good) -> pushed; same byte with parity 0 -> parity_err, no push.
//  5. Send 9 bytes 0x01..0x09 with no reads (depth 8) -> count=8, overrun pulses on 9th;
//     reads return 0x01..0x08 in order.
//  6. Fill FIFO, hold rd_en=1 during the next stop cycle -> no overrun, count stays 8;
//     assert rst=0 mid-byte -> rd_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receiver with 16x oversampling, mid-bit sampling, start-bit
//            glitch rejection, optional odd/even parity and a
//            first-word-fall-through receive FIFO.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low (0 = reset)
//            rx         - serial line, idle high, asynchronous to clk
//            rd_en      - pop the head entry (ignored while rd_valid=0)
//            rd_data    - FIFO head byte, valid while rd_valid=1 (0 when empty)
//            rd_valid   - FIFO not empty
//            fifo_count - number of stored entries
//            busy       - receiver FSM not idle
//            frame_err  - 1-cycle pulse, stop bit sampled low
//            parity_err - 1-cycle pulse, parity mismatch
//            overrun    - 1-cycle pulse, good byte dropped because FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY_MODE     = 0,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun
);

  // Oversampling tick divider; a zero divider would never tick, so clamp to 1.
  localparam int C_DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int C_DIV     = (C_DIV_RAW < 1) ? 1 : C_DIV_RAW;
  localparam int C_TICK_W  = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(C_DIV - 1);
  localparam logic [C_TICK_W-1:0] C_TICK_ONE  = C_TICK_W'(1);

  localparam int C_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(DATA_BITS - 1);
  localparam logic [C_BIT_W-1:0] C_BIT_ONE  = C_BIT_W'(1);

  localparam int C_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   C_FULL    = (FIFO_DEPTH_LOG2 + 1)'(C_DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   C_CNT_ONE = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] C_PTR_ONE = FIFO_DEPTH_LOG2'(1);

  localparam logic [3:0] C_MID = 4'd7;   // 8th tick: middle of start bit
  localparam logic [3:0] C_END = 4'd15;  // 16th tick: middle of next bit
  localparam logic [3:0] C_SMP_ONE = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic                       r_sync1;
  logic                       r_sync2;
  logic                       r_prev;
  logic [C_TICK_W-1:0]        r_tick_cnt;
  logic [3:0]                 r_sample_cnt;
  logic [C_BIT_W-1:0]         r_bit_cnt;
  logic [DATA_BITS-1:0]       r_shift;
  logic                       r_par_bad;
  logic [DATA_BITS-1:0]       r_mem [C_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_frame_err;
  logic                       r_parity_err;
  logic                       r_overrun;

  logic w_fall;
  logic w_tick;
  logic w_mid_tick;
  logic w_bit_tick;
  logic w_par_exp;
  logic w_resolve;
  logic w_good;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Two-flop synchroniser plus edge register; all preset to the idle level
  // so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall     = (r_state == ST_IDLE) && r_prev && !r_sync2;
  assign w_tick     = (r_tick_cnt == C_TICK_LAST);
  assign w_mid_tick = w_tick && (r_sample_cnt == C_MID);
  assign w_bit_tick = w_tick && (r_sample_cnt == C_END);
  assign w_par_exp  = (PARITY_MODE == 1) ? ~(^r_shift) : (^r_shift);

  // Free-running tick divider, re-phased on every start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_fall || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + C_TICK_ONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_fall) w_state_nxt = ST_START;
      ST_START:  if (w_mid_tick) w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_bit_tick && (r_bit_cnt == C_BIT_LAST))
                   w_state_nxt = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_tick) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_bit_tick) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Receive datapath: sample counter, bit counter, shifter, parity flag.
  // The sample counter sits at zero in IDLE, which also realises the clear
  // on the IDLE->START transition; it is re-zeroed at mid start bit so each
  // later bit is sampled on its 16th tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_sample_cnt <= '0;
      end else if ((r_state == ST_START) && w_mid_tick) begin
        r_sample_cnt <= '0;
      end else if (w_tick) begin
        r_sample_cnt <= r_sample_cnt + C_SMP_ONE;
      end

      if ((r_state == ST_START) && w_mid_tick) begin
        r_bit_cnt <= '0;
        r_par_bad <= 1'b0;
      end

      if ((r_state == ST_DATA) && w_bit_tick) begin
        r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
      end

      if ((r_state == ST_PARITY) && w_bit_tick) begin
        r_par_bad <= (r_sync2 != w_par_exp);
      end
    end
  end

  // Frame resolution in the middle of the stop bit; framing beats parity.
  assign w_resolve = (r_state == ST_STOP) && w_bit_tick;
  assign w_good    = w_resolve && r_sync2 && !r_par_bad;

  // FIFO control. A pop in the same cycle frees the slot, so a full FIFO
  // still accepts the byte when it is being read.
  assign w_full = (r_count == C_FULL);
  assign w_pop  = rd_en && (r_count != '0);
  assign w_push = w_good && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_CNT_ONE;
      end
      r_frame_err  <= w_resolve && !r_sync2;
      r_parity_err <= w_resolve && r_sync2 && r_par_bad;
      r_overrun    <= w_good && w_full && !w_pop;
    end
  end

  assign rd_valid   = (r_count != '0);
  assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign busy       = (r_state != ST_IDLE);
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire
